// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
//   Shared constants for the multiplexed 7-segment display blocks.
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF : segment patterns {g,f,e,d,c,b,a},
//     active-high, for a common-cathode display.
//   - AN_UNITS / AN_TENS              : bit positions inside an_o.
//   - sel_e                           : which digit slot the scanner is in.
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int AN_UNITS = 0;
  localparam int AN_TENS  = 1;

  typedef enum logic {
    SEL_UNITS = 1'b0,
    SEL_TENS  = 1'b1
  } sel_e;

  // Flip between the two digit slots.
  function automatic sel_e next_sel(input sel_e s);
    return (s == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//   Purely combinational BCD -> 7-segment decoder.
//   Ports:
//     bcd_i  in  4  digit value; 0-9 valid, 10-15 shown as a dash
//     seg_o  out 7  segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Codes outside 0-9 are not BCD; a dash makes the fault visible on the
  // display instead of showing a plausible-looking wrong digit.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
//   Drives a 2-digit multiplexed common-cathode 7-segment display from two
//   BCD digits. Digits are captured on load_i into shadow registers, copied
//   into the display registers at each slot boundary, time-multiplexed
//   units/tens, PWM-dimmed in 8 levels, with optional leading-zero blanking.
//   Parameter:
//     SCAN_DIV    log2 of clocks per digit slot (must be >= 3)
//   Ports:
//     clk         in   1  system clock
//     rst         in   1  asynchronous, active-high reset
//     digit10_i   in   4  tens digit, BCD
//     digit1_i    in   4  units digit, BCD
//     load_i      in   1  capture digit inputs into shadow regs this edge
//     blank_lz_i  in   1  blank the tens digit when it is 0
//     bright_i    in   3  brightness 0..7
//     seg_o       out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//     an_o        out  2  digit enables {tens,units}, one-hot or zero, registered
// ---------------------------------------------------------------------------
module bcd_display_scanner
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit10_i,
  input  logic [3:0] digit1_i,
  input  logic       load_i,
  input  logic       blank_lz_i,
  input  logic [2:0] bright_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o
);

  localparam logic [SCAN_DIV-1:0] P_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  logic [3:0]          shadow10_q, shadow10_d;
  logic [3:0]          shadow1_q,  shadow1_d;
  logic [3:0]          disp10_q,   disp10_d;
  logic [3:0]          disp1_q,    disp1_d;
  logic [SCAN_DIV-1:0] p_q,        p_d;
  sel_e                sel_q,      sel_d;
  logic [6:0]          seg_q,      seg_d;
  logic [1:0]          an_q,       an_d;

  logic                wrap;
  logic                lit;
  logic                blank_tens;
  logic [3:0]          digit_sel;
  logic [6:0]          pattern;
  logic [2:0]          p_top;

  assign wrap  = (p_q == '1);
  assign p_top = p_q[SCAN_DIV-1 -: 3];

  // Digit currently being scanned; fed to the shared decoder.
  assign digit_sel = (sel_q == SEL_TENS) ? disp10_q : disp1_q;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (pattern)
  );

  // Shadow capture and slot-boundary transfer. The display registers only
  // change on the last edge of a slot, so a load mid-slot never alters the
  // pattern of the slot in progress. Taking shadow_d (not shadow_q) means a
  // load on the very last edge of a slot still makes it into the next one.
  always_comb begin
    shadow10_d = shadow10_q;
    shadow1_d  = shadow1_q;
    if (load_i) begin
      shadow10_d = digit10_i;
      shadow1_d  = digit1_i;
    end
    disp10_d = disp10_q;
    disp1_d  = disp1_q;
    if (wrap) begin
      disp10_d = shadow10_d;
      disp1_d  = shadow1_d;
    end
  end

  // Free-running prescaler; the digit select flips as it wraps.
  always_comb begin
    p_d   = p_q + P_ONE;
    sel_d = wrap ? next_sel(sel_q) : sel_q;
  end

  // PWM and blanking. Count 0 of each slot is always dark so the segment
  // lines can settle on the new digit before its anode is enabled. The top
  // three prescaler bits form the PWM phase, so brightness b lights phases
  // 0..b, minus the dead cycle in phase 0.
  always_comb begin
    lit        = (p_q != '0) && (p_top <= bright_i);
    blank_tens = blank_lz_i && (disp10_q == 4'd0);
    seg_d      = pattern;
    an_d       = 2'b00;
    if (lit) begin
      if (sel_q == SEL_TENS) begin
        an_d[AN_TENS] = !blank_tens;
      end else begin
        an_d[AN_UNITS] = 1'b1;
      end
    end
  end

  // All state, including the registered outputs. Reset darkens the display
  // immediately and restarts scanning at the start of a units slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow10_q <= 4'd0;
      shadow1_q  <= 4'd0;
      disp10_q   <= 4'd0;
      disp1_q    <= 4'd0;
      p_q        <= '0;
      sel_q      <= SEL_UNITS;
      seg_q      <= SEG_OFF;
      an_q       <= 2'b00;
    end else begin
      shadow10_q <= shadow10_d;
      shadow1_q  <= shadow1_d;
      disp10_q   <= disp10_d;
      disp1_q    <= disp1_d;
      p_q        <= p_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scanner
//   Self-checking bench for bcd_display_scanner (SCAN_DIV = 6). A behavioural
//   model derived from the elapsed clock count since reset predicts seg_o and
//   an_o every cycle; directed scenarios add literal expectations for
//   decode values, PWM on-times, blanking, mid-slot loads and async reset.
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;

  localparam int SCAN_DIV = 6;
  localparam int SLOT     = 1 << SCAN_DIV;

  logic       clk;
  logic       rst;
  logic [3:0] digit10_i;
  logic [3:0] digit1_i;
  logic       load_i;
  logic       blank_lz_i;
  logic [2:0] bright_i;
  logic [6:0] seg_o;
  logic [1:0] an_o;

  int vectors;
  int miscompares;

  logic [6:0] seg_tab [0:15];

  bcd_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit10_i  (digit10_i),
    .digit1_i   (digit1_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .bright_i   (bright_i),
    .seg_o      (seg_o),
    .an_o       (an_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge so they are stable at every rising edge.
  task automatic applyStimulus(input logic [3:0] tens, input logic [3:0] units,
                               input logic ld, input logic blz, input logic [2:0] br);
    @(negedge clk);
    digit10_i  = tens;
    digit1_i   = units;
    load_i     = ld;
    blank_lz_i = blz;
    bright_i   = br;
  endtask

  task automatic loadDigits(input logic [3:0] tens, input logic [3:0] units,
                            input logic blz, input logic [2:0] br);
    applyStimulus(tens, units, 1'b1, blz, br);
    applyStimulus(tens, units, 1'b0, blz, br);
  endtask

  // Bounded wait for a given an_o value; the final compare flags a timeout.
  task automatic waitAn(input logic [1:0] target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (an_o !== target && n < 4 * SLOT);
    checkOutput("wait an_o", int'(an_o), int'(target));
  endtask

  // Observe a window: every lit cycle must show the right digit's pattern.
  task automatic scanWindow(input int cycles, input logic [6:0] exp_units,
                            input logic [6:0] exp_tens,
                            output int lit_cnt, output int tens_cnt);
    lit_cnt  = 0;
    tens_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (an_o != 2'b00) lit_cnt++;
      if (an_o == 2'b01) checkOutput("units seg", int'(seg_o), int'(exp_units));
      if (an_o == 2'b10) begin
        tens_cnt++;
        checkOutput("tens seg", int'(seg_o), int'(exp_tens));
      end
    end
  endtask

  // Behavioural reference: the k-th rising edge after reset release shows
  // prescaler count k mod SLOT of slot k / SLOT; even slots are units.
  // Digits shown in a slot are the shadow value at the end of the previous slot.
  int         k;
  logic [3:0] sh10, sh1, dp10, dp1;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;

  always @(posedge clk) begin
    int  p;
    int  slot_tens;
    logic [3:0] d;
    logic lit;
    if (rst) begin
      k       = 0;
      sh10    = 4'd0;
      sh1     = 4'd0;
      dp10    = 4'd0;
      dp1     = 4'd0;
      exp_seg = 7'h00;
      exp_an  = 2'b00;
    end else begin
      p         = k % SLOT;
      slot_tens = (k / SLOT) % 2;
      d         = (slot_tens == 1) ? dp10 : dp1;
      exp_seg   = seg_tab[d];
      lit       = (p != 0) && ((p / (SLOT / 8)) <= int'(bright_i));
      if (!lit || (slot_tens == 1 && blank_lz_i && dp10 == 4'd0))
        exp_an = 2'b00;
      else
        exp_an = (slot_tens == 1) ? 2'b10 : 2'b01;
      if (load_i) begin
        sh10 = digit10_i;
        sh1  = digit1_i;
      end
      if (p == SLOT - 1) begin
        dp10 = sh10;
        dp1  = sh1;
      end
      k++;
    end
    #2;
    checkOutput("model seg_o", int'(seg_o), int'(exp_seg));
    checkOutput("model an_o", int'(an_o), int'(exp_an));
  end

  initial begin
    int lit_cnt;
    int tens_cnt;
    logic [3:0] r10, r1;
    logic rblz;
    logic [2:0] rbr;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    digit10_i   = 4'd0;
    digit1_i    = 4'd0;
    load_i      = 1'b0;
    blank_lz_i  = 1'b0;
    bright_i    = 3'd7;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset seg_o", int'(seg_o), 0);
    checkOutput("reset an_o", int'(an_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // 42 at full brightness: 63 lit clocks per slot.
    loadDigits(4'd4, 4'd2, 1'b0, 3'd7);
    repeat (2 * SLOT + 4) @(posedge clk);
    scanWindow(4 * SLOT, 7'h5B, 7'h66, lit_cnt, tens_cnt);
    checkOutput("bright7 lit clocks", lit_cnt, 252);
    checkOutput("bright7 tens clocks", tens_cnt, 126);

    // 07 with leading-zero blanking, then without.
    loadDigits(4'd0, 4'd7, 1'b1, 3'd7);
    repeat (2 * SLOT + 4) @(posedge clk);
    scanWindow(4 * SLOT, 7'h07, 7'h3F, lit_cnt, tens_cnt);
    checkOutput("blanked tens clocks", tens_cnt, 0);
    checkOutput("blanked lit clocks", lit_cnt, 126);
    applyStimulus(4'd0, 4'd7, 1'b0, 1'b0, 3'd7);
    repeat (2) @(posedge clk);
    scanWindow(4 * SLOT, 7'h07, 7'h3F, lit_cnt, tens_cnt);
    checkOutput("unblanked tens clocks", tens_cnt, 126);

    // Invalid BCD shows dashes.
    loadDigits(4'hA, 4'hF, 1'b0, 3'd7);
    repeat (2 * SLOT + 4) @(posedge clk);
    scanWindow(4 * SLOT, 7'h40, 7'h40, lit_cnt, tens_cnt);
    checkOutput("dash lit clocks", lit_cnt, 252);

    // PWM on-time over four slots.
    loadDigits(4'd4, 4'd2, 1'b0, 3'd0);
    repeat (2 * SLOT + 4) @(posedge clk);
    scanWindow(4 * SLOT, 7'h5B, 7'h66, lit_cnt, tens_cnt);
    checkOutput("bright0 lit clocks", lit_cnt, 28);
    applyStimulus(4'd4, 4'd2, 1'b0, 1'b0, 3'd3);
    repeat (2) @(posedge clk);
    scanWindow(4 * SLOT, 7'h5B, 7'h66, lit_cnt, tens_cnt);
    checkOutput("bright3 lit clocks", lit_cnt, 124);

    // Mid-units-slot load: rest of the slot keeps the old pattern.
    applyStimulus(4'd4, 4'd2, 1'b0, 1'b0, 3'd7);
    waitAn(2'b10);
    waitAn(2'b01);
    loadDigits(4'd9, 4'd8, 1'b0, 3'd7);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      checkOutput("old units seg", int'(seg_o), 7'h5B);
    end
    waitAn(2'b10);
    checkOutput("new tens seg", int'(seg_o), 7'h6F);
    waitAn(2'b01);
    checkOutput("new units seg", int'(seg_o), 7'h7F);

    // Asynchronous reset mid-slot, then restart in the units slot.
    repeat (5) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    checkOutput("async rst seg_o", int'(seg_o), 0);
    checkOutput("async rst an_o", int'(an_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-rst dead an_o", int'(an_o), 0);
    @(posedge clk);
    #1;
    checkOutput("post-rst first lit an_o", int'(an_o), 1);
    checkOutput("post-rst first lit seg_o", int'(seg_o), 7'h3F);

    // Randomised traffic checked by the model on every cycle.
    rblz = 1'b0;
    rbr  = 3'd7;
    for (int i = 0; i < 3000; i++) begin
      r10 = 4'($urandom_range(0, 15));
      r1  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) rblz = ~rblz;
      if ($urandom_range(0, 31) == 0) rbr = 3'($urandom_range(0, 7));
      applyStimulus(r10, r1, ($urandom_range(0, 15) == 0), rblz, rbr);
    end
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 3'd7);
    repeat (3) @(posedge clk);
    #4;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
